// File: rtl/rx_pkg.sv
// Shared types, widths and the attenuation-to-shift map for the rx_receiver link front end.
package rx_pkg;

    localparam int PAYLOAD_W = 18;
    localparam int GUARD_W   = 3;
    localparam int FRAME_W   = PAYLOAD_W + GUARD_W;
    localparam int ATTEN_W   = 5;
    localparam int AVG_LOG2  = 2;
    localparam int ACC_W     = ATTEN_W + AVG_LOG2;
    localparam int LOS_LIMIT = 4;
    localparam int LOS_CNT_W = 3;
    localparam int ERR_CNT_W = 16;
    localparam int SHIFT_W   = 3;
    localparam int MAX_SHIFT = 4;

    localparam logic [ATTEN_W-1:0] ATTEN_REF = 5'd16;

    typedef enum logic [1:0] {
        ST_ACQUIRE = 2'd0,
        ST_TRACK   = 2'd1,
        ST_LOS     = 2'd2
    } rx_state_t;

    // Smallest shift that brings the averaged reference back up to ATTEN_REF.
    function automatic logic [SHIFT_W-1:0] avg_to_shift(input logic [ATTEN_W-1:0] avg);
        logic [SHIFT_W-1:0] shift;
        if (avg >= 5'd16)     shift = 3'd0;
        else if (avg >= 5'd8) shift = 3'd1;
        else if (avg >= 5'd4) shift = 3'd2;
        else if (avg >= 5'd2) shift = 3'd3;
        else                  shift = 3'd4;
        return shift;
    endfunction

endpackage

// File: rtl/rx_gain_comp.sv
// Stage-2 gain compensation: left-shifts the payload, saturating to all ones on overflow.
module rx_gain_comp
    import rx_pkg::*;
(
    input  logic [PAYLOAD_W-1:0] payload,
    input  logic [SHIFT_W-1:0]   shift,
    output logic [PAYLOAD_W-1:0] result
);

    localparam int WIDE_W = PAYLOAD_W + MAX_SHIFT;

    logic [WIDE_W-1:0] wide;

    // NOTE: every always_comb output is assigned on every path, so no latch is inferred.
    always_comb begin
        wide   = {{MAX_SHIFT{1'b0}}, payload} << shift;
        result = (wide[WIDE_W-1:PAYLOAD_W] != '0) ? '1 : wide[PAYLOAD_W-1:0];
    end

endmodule

// File: rtl/rx_receiver.sv
// Link receiver: acquires channel attenuation, strips guard bits, restores payload gain.
// Optional guard-error counter is built only when RX_GUARD_CHECK_EN is defined.
module rx_receiver
    import rx_pkg::*;
(
    input  logic                 CLOCK_50,
    input  logic                 RESET,
    input  logic [FRAME_W-1:0]   SIGNAL_IN,
    input  logic                 SIGNAL_VALID,
    input  logic [ATTEN_W-1:0]   ATTEN_IN,
    output logic [PAYLOAD_W-1:0] SIGNAL_OUT,
    output logic                 VALID_OUT,
    output logic [SHIFT_W-1:0]   GAIN_SHIFT,
    output logic                 LOCKED,
    output logic                 LOS,
    output logic [ERR_CNT_W-1:0] GUARD_ERR_CNT
);

    rx_state_t state, state_next;

    logic [ACC_W-1:0]           acc;
    logic [ACC_W-1:0]           acc_sum;
    logic [AVG_LOG2-1:0]        sample_cnt;
    logic [LOS_CNT_W-1:0]       los_cnt;
    logic [ATTEN_W-1:0]         atten_clamped;
    logic [ATTEN_W-1:0]         avg;
    logic                       window_done;
    logic                       los_hit;
    logic                       accept;
    logic                       s1_valid;
    logic [PAYLOAD_W-1:0]       s1_payload;
    logic [PAYLOAD_W-1:0]       comp_result;

    // Clamping prevents a hot reference from ever requesting negative gain.
    assign atten_clamped = (ATTEN_IN > ATTEN_REF) ? ATTEN_REF : ATTEN_IN;
    assign acc_sum       = acc + ACC_W'(atten_clamped);
    assign avg           = acc_sum[ACC_W-1:AVG_LOG2];
    assign window_done   = SIGNAL_VALID && (state == ST_ACQUIRE) && (sample_cnt == '1);
    assign los_hit       = SIGNAL_VALID && (state == ST_TRACK) && (ATTEN_IN == '0)
                           && (los_cnt == LOS_CNT_W'(LOS_LIMIT - 1));
    assign accept        = SIGNAL_VALID && (state == ST_TRACK);

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) state <= ST_ACQUIRE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_ACQUIRE: if (window_done) state_next = (avg == '0) ? ST_LOS : ST_TRACK;
            ST_TRACK:   if (los_hit) state_next = ST_LOS;
            ST_LOS:     if (SIGNAL_VALID && ATTEN_IN != '0) state_next = ST_ACQUIRE;
            default:    state_next = ST_ACQUIRE;
        endcase
    end

    always_comb begin
        LOCKED = 1'b0;
        LOS    = 1'b0;
        unique case (state)
            ST_TRACK: LOCKED = 1'b1;
            ST_LOS:   LOS    = 1'b1;
            default:  ;
        endcase
    end

    // The sample that exits LOS opens the new window as its first sample.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            acc        <= '0;
            sample_cnt <= '0;
            GAIN_SHIFT <= '0;
        end else begin
            unique case (state)
                ST_ACQUIRE: if (SIGNAL_VALID) begin
                    if (window_done) begin
                        acc        <= '0;
                        sample_cnt <= '0;
                        if (avg != '0) GAIN_SHIFT <= avg_to_shift(avg);
                    end else begin
                        acc        <= acc_sum;
                        sample_cnt <= sample_cnt + 1'b1;
                    end
                end
                ST_LOS: if (SIGNAL_VALID && ATTEN_IN != '0) begin
                    acc        <= ACC_W'(atten_clamped);
                    sample_cnt <= AVG_LOG2'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET || state != ST_TRACK) los_cnt <= '0;
        else if (SIGNAL_VALID)          los_cnt <= (ATTEN_IN == '0) ? los_cnt + 1'b1 : '0;
    end

    // NOTE: datapath registers are reset too, so no stale strobe or word survives a reset.
    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            s1_valid   <= 1'b0;
            s1_payload <= '0;
            VALID_OUT  <= 1'b0;
            SIGNAL_OUT <= '0;
        end else begin
            s1_valid  <= accept;
            if (accept) s1_payload <= SIGNAL_IN[FRAME_W-1:GUARD_W];
            // Drains regardless of state so words accepted before LOS still emerge.
            VALID_OUT <= s1_valid;
            if (s1_valid) SIGNAL_OUT <= comp_result;
        end
    end

    rx_gain_comp u_gain_comp (
        .payload (s1_payload),
        .shift   (GAIN_SHIFT),
        .result  (comp_result)
    );

`ifdef RX_GUARD_CHECK_EN
    always_ff @(posedge CLOCK_50) begin
        if (RESET)
            GUARD_ERR_CNT <= '0;
        else if (SIGNAL_VALID && SIGNAL_IN[GUARD_W-1:0] != '0 && GUARD_ERR_CNT != '1)
            GUARD_ERR_CNT <= GUARD_ERR_CNT + 1'b1;
    end
`else
    logic unused_guard;
    assign unused_guard  = |SIGNAL_IN[GUARD_W-1:0];
    assign GUARD_ERR_CNT = '0;
`endif

endmodule
